// File: rtl/imem_pp.sv
// Ping-pong input memory: the producer fills one bank while the consumer reads the other.
// Ownership of each bank passes between the two sides through the wr_done/rd_done handshakes.
module imem_pp #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 60,
  parameter int unsigned AW    = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr,
  input  logic [AW-1:0]    iaddr,
  input  logic [WIDTH-1:0] idata,
  input  logic             wr_done,
  output logic             wready,
  input  logic             rd,
  input  logic [AW-1:0]    oaddr,
  output logic [WIDTH-1:0] odata,
  output logic             ovalid,
  input  logic             rd_done,
  output logic             rready,
  output logic             wbank,
  output logic             rbank,
  output logic             err
);

  logic [WIDTH-1:0] mem_q [0:1][0:DEPTH-1];

  logic [1:0]       full_q, full_d;
  logic             wbank_q, wbank_d;
  logic             rbank_q, rbank_d;
  logic [WIDTH-1:0] odata_q, odata_d;
  logic             ovalid_q, ovalid_d;
  logic             err_q, err_d;

  logic             wr_in_range, rd_in_range;
  logic             wr_ok, rd_ok, wdone_ok, rdone_ok;
  logic [AW-1:0]    raddr;

  assign wready = ~full_q[wbank_q];
  assign rready = full_q[rbank_q];
  assign wbank  = wbank_q;
  assign rbank  = rbank_q;
  assign odata  = odata_q;
  assign ovalid = ovalid_q;
  assign err    = err_q;

  assign wr_in_range = 32'(iaddr) < DEPTH;
  assign rd_in_range = 32'(oaddr) < DEPTH;
  assign wr_ok       = wr & wready & wr_in_range;
  assign rd_ok       = rd & rready;
  assign wdone_ok    = wr_done & wready;
  assign rdone_ok    = rd_done & rready;
  // Clamp so an out-of-range read never indexes past the array.
  assign raddr       = rd_in_range ? oaddr : '0;

  always_comb begin
    full_d   = full_q;
    wbank_d  = wbank_q;
    rbank_d  = rbank_q;
    odata_d  = odata_q;
    ovalid_d = 1'b0;
    err_d    = err_q;

    if (wr && (!wready || !wr_in_range)) err_d = 1'b1;
    if (wr_done && !wready)              err_d = 1'b1;
    if (rd && !rready)                   err_d = 1'b1;
    if (rd_ok && !rd_in_range)           err_d = 1'b1;
    if (rd_done && !rready)              err_d = 1'b1;

    if (rd_ok) begin
      ovalid_d = 1'b1;
      odata_d  = rd_in_range ? mem_q[rbank_q][raddr] : '0;
    end

    // Same-index hand-offs can never both be accepted, so these never collide.
    if (wdone_ok) begin
      full_d[wbank_q] = 1'b1;
      wbank_d         = ~wbank_q;
    end
    if (rdone_ok) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q   <= 2'b00;
      wbank_q  <= 1'b0;
      rbank_q  <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      full_q   <= full_d;
      wbank_q  <= wbank_d;
      rbank_q  <= rbank_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem_q[wbank_q][iaddr] <= idata;
  end

endmodule

// File: tb/tb_imem_pp.sv
// Directed bench for imem_pp: fill/read, ping-pong, range errors, stalls, same-cycle
// hand-offs and asynchronous reset.
module tb_imem_pp;

  localparam int unsigned WIDTH = 9;
  localparam int unsigned DEPTH = 60;
  localparam int unsigned AW    = 6;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             wr, wr_done, rd, rd_done;
  logic [AW-1:0]    iaddr, oaddr;
  logic [WIDTH-1:0] idata;
  logic [WIDTH-1:0] odata;
  logic             wready, ovalid, rready, wbank, rbank, err;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  imem_pp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .wr      (wr),
    .iaddr   (iaddr),
    .idata   (idata),
    .wr_done (wr_done),
    .wready  (wready),
    .rd      (rd),
    .oaddr   (oaddr),
    .odata   (odata),
    .ovalid  (ovalid),
    .rd_done (rd_done),
    .rready  (rready),
    .wbank   (wbank),
    .rbank   (rbank),
    .err     (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wr = 0; wr_done = 0; rd = 0; rd_done = 0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [WIDTH-1:0] exp, input string tag);
    rd = 1; oaddr = a;
    tick();
    rd = 0;
    check({tag, "_valid"}, 32'(ovalid), 32'd1);
    check({tag, "_data"}, 32'(odata), 32'(exp));
  endtask

  initial begin
    idle();
    iaddr = '0; oaddr = '0; idata = '0;
    reset_n = 0;
    #12;
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_wbank",  32'(wbank),  32'd0);
    check("rst_rbank",  32'(rbank),  32'd0);
    check("rst_ovalid", 32'(ovalid), 32'd0);
    check("rst_odata",  32'(odata),  32'd0);
    check("rst_err",    32'(err),    32'd0);
    reset_n = 1;
    tick();

    // 1: fill bank 0 with its own addresses, then hand off
    for (int i = 0; i < 60; i++) begin
      wr = 1; iaddr = AW'(i); idata = WIDTH'(i);
      tick();
    end
    wr = 0; wr_done = 1;
    tick();
    wr_done = 0;
    check("t1_wbank",  32'(wbank),  32'd1);
    check("t1_rready", 32'(rready), 32'd1);
    check("t1_wready", 32'(wready), 32'd1);
    check("t1_rbank",  32'(rbank),  32'd0);
    do_read(6'd0,  9'h000, "t1_rd0");
    do_read(6'd59, 9'h03B, "t1_rd59");
    do_read(6'd30, 9'h01E, "t1_rd30");
    tick();
    check("t1_idle_valid", 32'(ovalid), 32'd0);
    check("t1_hold_data",  32'(odata),  32'h01E);

    // 2: fill bank 1 with 0x1FF while bank 0 is still being read
    for (int i = 0; i < 60; i++) begin
      wr = 1; iaddr = AW'(i); idata = 9'h1FF;
      rd = (i == 10); oaddr = 6'd10;
      tick();
      if (i == 10) check("t2_overlap_rd", 32'(odata), 32'h00A);
    end
    idle(); wr_done = 1;
    tick();
    wr_done = 0;
    check("t2_wready_full", 32'(wready), 32'd0);
    check("t2_wbank",       32'(wbank),  32'd0);
    rd_done = 1;
    tick();
    rd_done = 0;
    check("t2_rbank",  32'(rbank),  32'd1);
    check("t2_wready", 32'(wready), 32'd1);
    check("t2_rready", 32'(rready), 32'd1);
    do_read(6'd0,  9'h1FF, "t2_rd0");
    do_read(6'd59, 9'h1FF, "t2_rd59");
    check("t2_err", 32'(err), 32'd0);

    // 3: out-of-range write and read
    wr = 1; iaddr = 6'd60; idata = 9'h123;
    tick();
    wr = 0;
    check("t3_err_wr", 32'(err), 32'd1);
    do_read(6'd63, 9'h000, "t3_rd63");
    check("t3_err_sticky", 32'(err), 32'd1);

    // 5a: write plus wr_done in one cycle; both banks now full
    wr = 1; iaddr = 6'd5; idata = 9'h0AA; wr_done = 1;
    tick();
    idle();
    check("t5a_wready", 32'(wready), 32'd0);
    check("t5a_wbank",  32'(wbank),  32'd1);
    // 4a: write while both full is dropped
    wr = 1; iaddr = 6'd5; idata = 9'h155;
    tick();
    wr = 0;
    check("t4_wbank_hold", 32'(wbank), 32'd1);
    check("t4_rbank_hold", 32'(rbank), 32'd1);
    // 5b: read plus rd_done reads the old bank, then releases it
    rd = 1; oaddr = 6'd7; rd_done = 1;
    tick();
    idle();
    check("t5b_data",   32'(odata),  32'h1FF);
    check("t5b_valid",  32'(ovalid), 32'd1);
    check("t5b_rbank",  32'(rbank),  32'd0);
    check("t5b_wready", 32'(wready), 32'd1);
    do_read(6'd5, 9'h0AA, "t5a_landed");
    do_read(6'd4, 9'h004, "t5_bank0_keep");
    // 5c: wr_done (bank 1) and rd_done (bank 0) together
    wr_done = 1; rd_done = 1;
    tick();
    idle();
    check("t5c_wbank",  32'(wbank),  32'd0);
    check("t5c_rbank",  32'(rbank),  32'd1);
    check("t5c_wready", 32'(wready), 32'd1);
    check("t5c_rready", 32'(rready), 32'd1);
    do_read(6'd5, 9'h1FF, "t4_drop_kept");
    // 4b: release bank 1, both empty, read stalls
    rd_done = 1;
    tick();
    rd_done = 0;
    check("t4_rready", 32'(rready), 32'd0);
    rd = 1; oaddr = 6'd1;
    tick();
    rd = 0;
    check("t4_rd_valid", 32'(ovalid), 32'd0);
    check("t4_rd_hold",  32'(odata),  32'h1FF);
    check("t4_rbank",    32'(rbank),  32'd0);
    check("t4_wbank",    32'(wbank),  32'd0);
    // Same index, bank 0 empty: only wr_done is accepted
    wr_done = 1; rd_done = 1;
    tick();
    idle();
    check("same_wbank",  32'(wbank),  32'd1);
    check("same_rbank",  32'(rbank),  32'd0);
    check("same_rready", 32'(rready), 32'd1);

    // 6: partial fill of bank 1 and a read in flight, then reset
    wr = 1; iaddr = 6'd0; idata = 9'h055;
    tick();
    wr = 0;
    do_read(6'd3, 9'h003, "t6_pre_rd");
    check("t6_err_pre", 32'(err), 32'd1);
    #1 reset_n = 0;
    #1;
    check("t6_ovalid", 32'(ovalid), 32'd0);
    check("t6_odata",  32'(odata),  32'd0);
    check("t6_wbank",  32'(wbank),  32'd0);
    check("t6_rbank",  32'(rbank),  32'd0);
    check("t6_err",    32'(err),    32'd0);
    #5 reset_n = 1;
    tick();
    check("t6_wready", 32'(wready), 32'd1);
    check("t6_rready", 32'(rready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
